// File: rtl/fir_out_decim.sv
// fir_out_decim: output stage after the FIR socket.
//   Keeps every DECIM-th strobed input sample, round-scales it by SHIFT, saturates it to
//   OUT_WIDTH bits and queues it in a DEPTH-word first-word-fall-through FIFO.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_sample, in_valid    filtered sample and its one-cycle strobe
//   out_data, out_valid    FIFO head and non-empty flag
//   out_ready              consumer accepts out_data this cycle
//   count                  FIFO occupancy
//   sat                    pulse: stage-1 register holds a clipped value
//   overflow               sticky: a kept sample was dropped on a full FIFO
module fir_out_decim #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 8,
  parameter int unsigned DECIM     = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_sample,
  input  logic                         in_valid,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         sat,
  output logic                         overflow
);

  localparam int unsigned PhW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned RndSh = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [WIDTH:0] Rnd = (SHIFT > 0) ? ((WIDTH + 1)'(1) << RndSh) : '0;
  localparam logic signed [WIDTH:0] MaxV = (WIDTH + 1)'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [WIDTH:0] MinV = ~MaxV;

  // Decimation phase
  logic [PhW-1:0] phase_q, phase_d;
  logic           keep;

  // Stage 1
  logic                 s1_valid_q, s1_valid_d;
  logic [OUT_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                 sat_q, sat_d;
  logic signed [WIDTH:0] ext, sum, scaled, clip_v;
  logic                  clipped;

  // FIFO
  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [OUT_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CntW-1:0]      count_q, count_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop, full, accept;

  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  assign keep = in_valid && (phase_q == '0);

  // Round half up: add half an LSB of the scaled result, then arithmetic shift.
  always_comb begin
    ext     = $signed({in_sample[WIDTH-1], in_sample});
    sum     = ext + $signed(Rnd);
    scaled  = sum >>> SHIFT;
    clip_v  = scaled;
    clipped = 1'b0;
    if (scaled > MaxV) begin
      clip_v  = MaxV;
      clipped = 1'b1;
    end else if (scaled < MinV) begin
      clip_v  = MinV;
      clipped = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = keep;
    s1_data_d  = keep ? OUT_WIDTH'(clip_v) : s1_data_q;
    sat_d      = keep & clipped;
  end

  assign push   = s1_valid_q;
  assign pop    = (count_q != '0) && out_ready;
  assign full   = (count_q == CntW'(DEPTH));
  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign accept = push && (!full || pop);
  assign rd_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (accept) begin
      mem_d[wr_ptr_q] = s1_data_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_nxt;
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Registered head: follows the next stored word, or the incoming word when it
    // becomes the head; otherwise holds its last value.
    if (pop) begin
      if (count_q > CntW'(1)) begin
        out_data_d = mem_q[rd_nxt];
      end else if (accept) begin
        out_data_d = s1_data_q;
      end
    end else if ((count_q == '0) && accept) begin
      out_data_d = s1_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sat_q      <= sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign sat       = sat_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim with default parameters.
module tb_fir_out_decim;

  logic        clk;
  logic        rst_n;
  logic [23:0] in_sample;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        sat;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fir_out_decim dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .sat       (sat),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [23:0] s);
    in_sample = s;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_sample = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_sat", sat, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", $signed(out_data), 0);

    // 1: scale 4736/256 = 18.5 -> 19, visible two edges after the strobe
    strobe(24'd4736);
    check("t1_valid_lat1", out_valid, 0);
    check("t1_sat", sat, 0);
    step();
    check("t1_valid_lat2", out_valid, 1);
    check("t1_data", $signed(out_data), 19);
    check("t1_count", count, 1);

    // 2: saturation both ends
    do_reset();
    strobe(24'h7FFFFF);
    check("t2_sat_pulse", sat, 1);
    step();
    check("t2_sat_clear", sat, 0);
    check("t2_pos_data", $signed(out_data), 32767);
    strobe(24'd1);
    strobe(24'd2);
    strobe(24'd3);
    strobe(24'h800000);
    check("t2_neg_sat", sat, 0);
    step();
    check("t2_count", count, 2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_neg_data", $signed(out_data), -32768);
    check("t2_count_pop", count, 1);

    // 3: decimation of 8 back-to-back strobes keeps samples 1 and 5
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      in_sample = 24'(k * 256);
      in_valid  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t3_count", count, 2);
    check("t3_head1", $signed(out_data), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_head5", $signed(out_data), 5);
    check("t3_count_pop", count, 1);
    strobe(24'(9 * 256));
    step();
    check("t3_phase_wrap", count, 2);

    // 4: five kept samples into a 4-deep FIFO with no consumer
    do_reset();
    for (int j = 0; j < 20; j++) begin
      in_sample = (j % 4 == 0) ? 24'(((j / 4) + 1) * 10 * 256) : 24'd0;
      in_valid  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t4_count_full", count, 4);
    check("t4_overflow", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", $signed(out_data), (i + 1) * 10);
      step();
    end
    out_ready = 1'b0;
    check("t4_empty", out_valid, 0);
    check("t4_hold", $signed(out_data), 40);
    check("t4_ovf_sticky", overflow, 1);

    // 5: push into a full FIFO while popping
    do_reset();
    for (int j = 0; j < 16; j++) begin
      in_sample = (j % 4 == 0) ? 24'(((j / 4) + 1) * 256) : 24'd0;
      in_valid  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t5_count_full", count, 4);
    check("t5_head", $signed(out_data), 1);
    strobe(24'(5 * 256));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_count_same", count, 4);
    check("t5_no_overflow", overflow, 0);
    check("t5_head_next", $signed(out_data), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain", $signed(out_data), i + 2);
      step();
    end
    out_ready = 1'b0;
    check("t5_empty", count, 0);

    // 6: asynchronous reset mid-cycle with phase left non-zero
    do_reset();
    for (int j = 0; j < 5; j++) begin
      in_sample = 24'((j + 1) * 256);
      in_valid  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t6_count_pre", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_count", count, 0);
    check("t6_async_ovf", overflow, 0);
    step();
    rst_n = 1'b1;
    strobe(24'(7 * 256));
    step();
    check("t6_first_kept_cnt", count, 1);
    check("t6_first_kept_data", $signed(out_data), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
